// File: rtl/alert_arbiter.sv
// alert_arbiter
//   Drives the single piezo buzzer for three alert sources: the alarm match,
//   timer expiry and the top-of-hour chime. It applies fixed priority
//   (alarm > timer > chime) with preemption, gives each source its own beep
//   pattern, silences automatically after a timeout, and provides alarm
//   snooze plus a sticky missed-alarm flag. clk is the 1 Hz tick, so one
//   cycle is one second.
//
// Ports
//   clk          in   1 Hz system clock, posedge
//   reset        in   asynchronous, active-high
//   enable       in   master alert enable
//   alarm_req    in   alarm comparator level (rising edge requests)
//   timer_req    in   timer expiry level (rising edge requests)
//   chime_req    in   one-cycle pulse at hour rollover
//   stop_btn     in   dismiss current alert / cancel snooze / clear missed
//   snooze_btn   in   snooze an active alarm
//   buzzer       out  registered buzzer drive
//   active_src   out  00 none, 01 alarm, 10 timer, 11 chime
//   snoozed      out  high while the snooze countdown runs
//   alarm_missed out  sticky: an alarm timed out unanswered
//
// state    | meaning
// ---------+------------------------------------------------------
// ST_IDLE  | silent; grants the highest-priority pending source
// ST_ALARM | alarm sounding, buzzer toggles every cycle
// ST_TIMER | timer alert, buzzer steady; alarm may preempt
// ST_CHIME | hourly chime, steady for CHIME_SEC cycles
module alert_arbiter #(
  parameter int TIMEOUT_SEC = 60,
  parameter int SNOOZE_SEC  = 300,
  parameter int CHIME_SEC   = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       alarm_req,
  input  logic       timer_req,
  input  logic       chime_req,
  input  logic       stop_btn,
  input  logic       snooze_btn,
  output logic       buzzer,
  output logic [1:0] active_src,
  output logic       snoozed,
  output logic       alarm_missed
);

  localparam int DUR_MAX = (TIMEOUT_SEC > CHIME_SEC) ? TIMEOUT_SEC : CHIME_SEC;
  localparam int DUR_W   = $clog2(DUR_MAX + 1);
  localparam int SNZ_W   = $clog2(SNOOZE_SEC + 1);

  localparam logic [DUR_W-1:0] DUR_TIMEOUT_LAST = DUR_W'(TIMEOUT_SEC - 1);
  localparam logic [DUR_W-1:0] DUR_CHIME_LAST   = DUR_W'(CHIME_SEC - 1);
  localparam logic [SNZ_W-1:0] SNZ_LOAD         = SNZ_W'(SNOOZE_SEC - 1);

  // Encoding doubles as the active_src code.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ALARM = 2'b01,
    ST_TIMER = 2'b10,
    ST_CHIME = 2'b11
  } state_t;

  state_t           state_q, state_d;
  logic             buzzer_q, buzzer_d;
  logic [DUR_W-1:0] dur_q, dur_d;
  logic [SNZ_W-1:0] snz_cnt_q, snz_cnt_d;
  logic             snoozed_q, snoozed_d;
  logic             missed_q, missed_d;
  logic             pend_alarm_q, pend_alarm_d;
  logic             pend_timer_q, pend_timer_d;
  logic             pend_chime_q, pend_chime_d;
  logic             alarm_prev_q, alarm_prev_d;
  logic             timer_prev_q, timer_prev_d;
  logic             snz_fire;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      buzzer_q     <= 1'b0;
      dur_q        <= '0;
      snz_cnt_q    <= '0;
      snoozed_q    <= 1'b0;
      missed_q     <= 1'b0;
      pend_alarm_q <= 1'b0;
      pend_timer_q <= 1'b0;
      pend_chime_q <= 1'b0;
      alarm_prev_q <= 1'b0;
      timer_prev_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      buzzer_q     <= buzzer_d;
      dur_q        <= dur_d;
      snz_cnt_q    <= snz_cnt_d;
      snoozed_q    <= snoozed_d;
      missed_q     <= missed_d;
      pend_alarm_q <= pend_alarm_d;
      pend_timer_q <= pend_timer_d;
      pend_chime_q <= pend_chime_d;
      alarm_prev_q <= alarm_prev_d;
      timer_prev_q <= timer_prev_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    buzzer_d     = buzzer_q;
    dur_d        = dur_q;
    snz_cnt_d    = snz_cnt_q;
    snoozed_d    = snoozed_q;
    missed_d     = missed_q;
    pend_alarm_d = pend_alarm_q;
    pend_timer_d = pend_timer_q;
    pend_chime_d = pend_chime_q;
    alarm_prev_d = alarm_req;
    timer_prev_d = timer_req;
    snz_fire     = 1'b0;

    // Snooze countdown runs in every state; stop cancels it outright.
    if (snoozed_q) begin
      if (snz_cnt_q == '0) begin
        snoozed_d = 1'b0;
        snz_fire  = !stop_btn;
      end else begin
        snz_cnt_d = snz_cnt_q - SNZ_W'(1);
      end
    end
    if (stop_btn) snoozed_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (pend_alarm_q) begin
          state_d      = ST_ALARM;
          buzzer_d     = 1'b1;
          dur_d        = '0;
          pend_alarm_d = 1'b0;
        end else if (pend_timer_q) begin
          state_d      = ST_TIMER;
          buzzer_d     = 1'b1;
          dur_d        = '0;
          pend_timer_d = 1'b0;
        end else if (pend_chime_q) begin
          state_d      = ST_CHIME;
          buzzer_d     = 1'b1;
          dur_d        = '0;
          pend_chime_d = 1'b0;
        end
      end
      ST_ALARM: begin
        if (stop_btn) begin
          state_d      = ST_IDLE;
          buzzer_d     = 1'b0;
          dur_d        = '0;
          pend_alarm_d = 1'b0;
        end else if (snooze_btn) begin
          state_d   = ST_IDLE;
          buzzer_d  = 1'b0;
          dur_d     = '0;
          snoozed_d = 1'b1;
          snz_cnt_d = SNZ_LOAD;
        end else if (dur_q == DUR_TIMEOUT_LAST) begin
          state_d  = ST_IDLE;
          buzzer_d = 1'b0;
          dur_d    = '0;
          missed_d = 1'b1;
        end else begin
          dur_d    = dur_q + DUR_W'(1);
          buzzer_d = !buzzer_q;
        end
      end
      ST_TIMER: begin
        if (stop_btn) begin
          state_d      = ST_IDLE;
          buzzer_d     = 1'b0;
          dur_d        = '0;
          pend_timer_d = 1'b0;
        end else if (pend_alarm_q) begin
          // Preempted timer re-pends and restarts with a fresh count later.
          state_d      = ST_ALARM;
          buzzer_d     = 1'b1;
          dur_d        = '0;
          pend_alarm_d = 1'b0;
          pend_timer_d = 1'b1;
        end else if (dur_q == DUR_TIMEOUT_LAST) begin
          state_d  = ST_IDLE;
          buzzer_d = 1'b0;
          dur_d    = '0;
        end else begin
          dur_d    = dur_q + DUR_W'(1);
          buzzer_d = 1'b1;
        end
      end
      ST_CHIME: begin
        if (stop_btn) begin
          state_d      = ST_IDLE;
          buzzer_d     = 1'b0;
          dur_d        = '0;
          pend_chime_d = 1'b0;
        end else if (pend_alarm_q) begin
          // Preempted chime is dropped, not re-pended.
          state_d      = ST_ALARM;
          buzzer_d     = 1'b1;
          dur_d        = '0;
          pend_alarm_d = 1'b0;
          pend_chime_d = 1'b0;
        end else if (dur_q == DUR_CHIME_LAST) begin
          state_d  = ST_IDLE;
          buzzer_d = 1'b0;
          dur_d    = '0;
        end else begin
          dur_d    = dur_q + DUR_W'(1);
          buzzer_d = 1'b1;
        end
      end
      default: begin
        state_d  = ST_IDLE;
        buzzer_d = 1'b0;
        dur_d    = '0;
      end
    endcase

    // Captures are applied after the FSM clears so a new request on the
    // same edge as a dismissal survives.
    if (enable) begin
      if ((alarm_req && !alarm_prev_q) || snz_fire) pend_alarm_d = 1'b1;
      if (timer_req && !timer_prev_q) pend_timer_d = 1'b1;
      if (chime_req && (state_q == ST_IDLE || state_q == ST_CHIME)) pend_chime_d = 1'b1;
    end else begin
      state_d      = ST_IDLE;
      buzzer_d     = 1'b0;
      dur_d        = '0;
      pend_alarm_d = 1'b0;
      pend_timer_d = 1'b0;
      pend_chime_d = 1'b0;
      snoozed_d    = 1'b0;
      snz_cnt_d    = '0;
      missed_d     = missed_q;
    end

    if (stop_btn) missed_d = 1'b0;
  end

  assign buzzer       = buzzer_q;
  assign active_src   = state_q;
  assign snoozed      = snoozed_q;
  assign alarm_missed = missed_q;

endmodule

// File: doc/alert_arbiter.md
Name: alert_arbiter

Overview:
- Shares the single piezo buzzer between three alert sources: the alarm match, timer expiry and the top-of-hour chime.
- Applies fixed priority and preemption, generates a per-source beep pattern, and auto-silences after a timeout.
- Implements alarm snooze and a sticky missed-alarm flag.
- Sits between clock_with_mode_fsm (alarm_buzzer, timer_buzzer, hour rollover) and the board buzzer pin. clk is the 1 Hz system tick, so one cycle equals one second.

Parameters:
- TIMEOUT_SEC, 60: cycles an alarm or timer alert sounds before auto-silence.
- SNOOZE_SEC, 300: snooze delay in cycles before the alarm re-fires.
- CHIME_SEC, 2: cycles the hourly chime sounds.

Ports:
- clk  in  1  1 Hz system clock; all logic on posedge.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  master alert enable.
- alarm_req  in  1  level from the alarm comparator (alarm_buzzer).
- timer_req  in  1  level from the timer block (timer_buzzer).
- chime_req  in  1  one-cycle pulse at each hour rollover.
- stop_btn  in  1  dismisses the current alert; sampled each edge.
- snooze_btn  in  1  snoozes an active alarm; sampled each edge.
- buzzer  out  1  registered buzzer drive.
- active_src  out  2  00 none, 01 alarm, 10 timer, 11 chime.
- snoozed  out  1  high while the snooze countdown runs.
- alarm_missed  out  1  sticky; an alarm auto-timed-out unanswered.

Behaviour:
- Reset (asynchronous) clears everything: state IDLE, buzzer=0, active_src=00, snoozed=0, alarm_missed=0, all pending bits and counters=0, edge-detect registers=0.
- Request capture:
  - alarm_req and timer_req are rising-edge detected against registered copies.
  - A rising edge, or a chime_req high, sets the matching pending bit at that edge.
  - While enable=0, no request is captured.
- States: IDLE, ALARM, TIMER, CHIME. All outputs are registered and update on the same edge as the state.
- Grant from IDLE: at the edge after a pending bit is visible, the highest-priority pending source is served.
  - Priority: alarm > timer > chime.
  - On entry: buzzer=1, duration counter=0, active_src set, that source's pending bit cleared.
  - Latency is 2 edges from the request rise to buzzer=1.
- Patterns while a source is served:
  - ALARM: buzzer toggles every cycle (1 s on / 1 s off).
  - TIMER: buzzer held at 1.
  - CHIME: buzzer held at 1 for CHIME_SEC cycles, then IDLE.
- Timeout:
  - In ALARM or TIMER the counter increments each edge.
  - At the edge where it would reach TIMEOUT_SEC, the block goes to IDLE with buzzer=0.
  - An ALARM timeout also sets alarm_missed=1.
- Preemption:
  - An alarm pending during TIMER or CHIME preempts at the next edge.
  - A preempted timer re-pends and is re-served with a fresh counter after the alarm ends.
  - A preempted chime is dropped.
  - A chime_req arriving during ALARM or TIMER is discarded.
- stop_btn:
  - In any non-IDLE state: go to IDLE next edge, buzzer=0, clear the served source's pending bit.
  - In any state: cancels a running snooze (snoozed=0) and clears alarm_missed.
- snooze_btn:
  - Acts only in ALARM: go to IDLE, buzzer=0, snoozed=1, snooze counter loaded with SNOOZE_SEC-1.
  - Ignored in every other state.
- Snooze countdown:
  - Decrements every edge regardless of state.
  - At 0: snoozed=0 and alarm pending is set, so the alarm is served on the following edge if nothing higher is active.
- Simultaneous events:
  - stop_btn and snooze_btn together: stop wins.
  - Alarm rise and timer rise on the same edge: both pend, alarm is served first.
  - Pending set and stop on the same edge: the new pending survives.
- enable falling to 0: at the next edge the block goes to IDLE, buzzer=0, pending bits and snooze are cleared; alarm_missed is held.
- Reset mid-alert silences immediately (asynchronous) and discards all pending and snooze state.
- Counter widths are $clog2(param+1); there is no wrap, since counters are reloaded or cleared on every entry.

Test Plan:
- Alarm, no interaction: alarm_req rises at cycle 10 → buzzer=1 at cycle 12 then toggles; active_src=01 for 60 cycles; then buzzer=0, alarm_missed=1. stop_btn later → alarm_missed=0.
- Timer preempted by alarm: timer_req rises at cycle 5, alarm_req rises at cycle 20 → active_src goes 10→01 at cycle 22. stop_btn at cycle 30 → timer re-served at cycle 32 with steady buzzer for a full 60 cycles.
- Snooze: in ALARM, snooze_btn for 1 cycle → buzzer=0, snoozed=1 for 300 cycles, then active_src=01 and the alarm re-sounds. Repeat the snooze, then stop_btn mid-countdown → snoozed=0 and no re-fire.
- Chime: chime_req pulse while IDLE → buzzer=1 for exactly 2 cycles, active_src=11. Chime pulse during TIMER → ignored, no chime afterwards.
- Simultaneous and enable: stop_btn+snooze_btn together in ALARM → IDLE, snoozed=0. Dropping enable during TIMER → IDLE next edge; requests while disabled produce no alert after re-enable.
- Async reset asserted mid-ALARM between clock edges → buzzer=0 and active_src=00 immediately; no re-fire after release.
